mem_stage: RTL and testbench

- Pipeline stage directly downstream of the EXE stage. Consumes the EXE result (ALU result or effective address) plus pass-through control.
- Performs data-memory loads and stores over a req/ack bus. Registers the write-back record for WB.
- Stalls EXE through a valid/ready handshake while a bus access is outstanding.

---
 rtl/proc_pkg.sv | 18 +
 rtl/mem_timeout_ctr.sv | 33 +++
 rtl/mem_stage.sv | 131 +++++++++++++
 tb/tb_mem_stage.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared types and widths for the processor pipeline stages.
// The MEM stage FSM encoding lives here so other stages can decode it if needed.
package proc_pkg;

   localparam int unsigned REG_W  = 4;
   localparam int unsigned DATA_W = 32;

   typedef enum logic {
      StIdle = 1'b0,
      StBus  = 1'b1
   } mem_state_e;

   // Word accesses only: both low address bits must be clear.
   function automatic logic word_aligned(input logic [DATA_W-1:0] addr);
      return addr[1:0] == 2'b00;
   endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Loadable up-counter with synchronous clear, enable and terminal-count flag.
// Used by mem_stage to bound how long a bus access may wait for its ack.
module mem_timeout_ctr #(
   parameter int unsigned    W      = 8,
   parameter logic [W-1:0]   TC_VAL = '1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         tc
);

   logic [W-1:0] cnt_q;

   // Clear has priority over load, load over count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (en) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: passes ALU results through to WB and performs word loads/stores
// over a req/ack bus, stalling EXE while an access is outstanding.
module mem_stage
   import proc_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] exe_out,
   input  logic [DATA_W-1:0] rs2_val,
   input  logic              is_load_store,
   input  logic              is_store,
   input  logic [REG_W-1:0]  rd,
   input  logic              rd_we,
   input  logic [DATA_W-1:0] pc_in,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ack,
   output logic              wb_valid,
   output logic              wb_we,
   output logic [REG_W-1:0]  wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic [DATA_W-1:0] wb_pc,
   output logic              align_err,
   output logic              bus_err
);

   localparam int unsigned CTR_W = 8;

   mem_state_e          state_q;
   logic [REG_W-1:0]    rd_q;
   logic [DATA_W-1:0]   pc_q;
   logic                bus_start;
   logic                timeout_tc;

   assign in_ready  = (state_q == StIdle);
   assign bus_start = in_ready && in_valid && is_load_store && word_aligned(exe_out);

   // Counter reads k during the (k+1)-th BUS cycle, so TC at TIMEOUT-1 marks the last one.
   mem_timeout_ctr #(
      .W      (CTR_W),
      .TC_VAL (CTR_W'(TIMEOUT - 1))
   ) u_timeout_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (bus_start),
      .load     (1'b0),
      .load_val ('0),
      .en       (state_q == StBus),
      .tc       (timeout_tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         rd_q       <= '0;
         pc_q       <= '0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         wb_valid   <= 1'b0;
         wb_we      <= 1'b0;
         wb_rd      <= '0;
         wb_data    <= '0;
         wb_pc      <= '0;
         align_err  <= 1'b0;
         bus_err    <= 1'b0;
      end else begin
         wb_valid  <= 1'b0;
         align_err <= 1'b0;
         bus_err   <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (in_valid && !is_load_store) begin
                  wb_valid <= 1'b1;
                  wb_we    <= rd_we;
                  wb_rd    <= rd;
                  wb_data  <= exe_out;
                  wb_pc    <= pc_in;
               end else if (in_valid && !word_aligned(exe_out)) begin
                  align_err <= 1'b1;
                  wb_valid  <= 1'b1;
                  wb_we     <= 1'b0;
                  wb_rd     <= rd;
                  wb_data   <= '0;
                  wb_pc     <= pc_in;
               end else if (bus_start) begin
                  state_q    <= StBus;
                  rd_q       <= rd;
                  pc_q       <= pc_in;
                  dmem_req   <= 1'b1;
                  dmem_we    <= is_store;
                  dmem_addr  <= exe_out[ADDR_W-1:0];
                  dmem_wdata <= rs2_val;
               end
            end
            StBus: begin
               // Ack takes priority over a timeout landing in the same cycle.
               if (dmem_ack) begin
                  state_q  <= StIdle;
                  dmem_req <= 1'b0;
                  wb_valid <= 1'b1;
                  wb_we    <= !dmem_we;
                  wb_rd    <= rd_q;
                  wb_data  <= dmem_we ? '0 : dmem_rdata;
                  wb_pc    <= pc_q;
               end else if (timeout_tc) begin
                  state_q  <= StIdle;
                  dmem_req <= 1'b0;
                  bus_err  <= 1'b1;
                  wb_valid <= 1'b1;
                  wb_we    <= 1'b0;
                  wb_rd    <= rd_q;
                  wb_data  <= '0;
                  wb_pc    <= pc_q;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of single-cycle ops, then hand-written bus sequences.
module tb_mem_stage;

   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid, in_ready;
   logic [31:0] exe_out, rs2_val, pc_in;
   logic        is_load_store, is_store, rd_we;
   logic [3:0]  rd;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        wb_valid, wb_we, align_err, bus_err;
   logic [3:0]  wb_rd;
   logic [31:0] wb_data, wb_pc;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_stage #(
      .ADDR_W  (ADDR_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .exe_out       (exe_out),
      .rs2_val       (rs2_val),
      .is_load_store (is_load_store),
      .is_store      (is_store),
      .rd            (rd),
      .rd_we         (rd_we),
      .pc_in         (pc_in),
      .dmem_req      (dmem_req),
      .dmem_we       (dmem_we),
      .dmem_addr     (dmem_addr),
      .dmem_wdata    (dmem_wdata),
      .dmem_rdata    (dmem_rdata),
      .dmem_ack      (dmem_ack),
      .wb_valid      (wb_valid),
      .wb_we         (wb_we),
      .wb_rd         (wb_rd),
      .wb_data       (wb_data),
      .wb_pc         (wb_pc),
      .align_err     (align_err),
      .bus_err       (bus_err)
   );

   typedef struct {
      logic        valid, ls, st, we;
      logic [31:0] exe, pc;
      logic [3:0]  rd;
      logic        e_valid, e_we, e_align, e_chk_data;
      logic [3:0]  e_rd;
      logic [31:0] e_data, e_pc;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; is_load_store = 1'b0; is_store = 1'b0; rd_we = 1'b0;
      exe_out = '0; rs2_val = '0; rd = '0; pc_in = '0;
   endtask

   task automatic issue_mem(input logic st, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] r, input logic [31:0] pc);
      in_valid = 1'b1; is_load_store = 1'b1; is_store = st; rd_we = 1'b0;
      exe_out = addr; rs2_val = wd; rd = r; pc_in = pc;
   endtask

   initial begin
      int req_cycles;
      int err_cycle;

      idle_inputs();
      dmem_ack = 1'b0;
      dmem_rdata = '0;

      // Reset state
      #2;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_dmem_req", dmem_req, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_align_err", align_err, 0);
      chk("rst_bus_err", bus_err, 0);
      chk("rst_wb_data", wb_data, 0);
      step();
      rst_n = 1'b1;
      step();

      // Single-cycle ops
      vecs[0] = '{1,0,0,1, 32'h11,  32'h10, 4'd1, 1,1,0,1, 4'd1, 32'h11, 32'h10};
      vecs[1] = '{1,0,0,1, 32'h22,  32'h14, 4'd2, 1,1,0,1, 4'd2, 32'h22, 32'h14};
      vecs[2] = '{1,0,0,1, 32'h33,  32'h18, 4'd3, 1,1,0,1, 4'd3, 32'h33, 32'h18};
      vecs[3] = '{0,0,0,0, 32'h0,   32'h0,  4'd0, 0,1,0,1, 4'd3, 32'h33, 32'h18};
      vecs[4] = '{1,0,0,0, 32'h44,  32'h1c, 4'd4, 1,0,0,1, 4'd4, 32'h44, 32'h1c};
      vecs[5] = '{1,1,0,0, 32'h102, 32'h20, 4'd6, 1,0,1,0, 4'd6, 32'h0,  32'h20};
      vecs[6] = '{1,1,1,0, 32'h203, 32'h24, 4'd0, 1,0,1,0, 4'd0, 32'h0,  32'h24};
      vecs[7] = '{0,0,0,0, 32'h0,   32'h0,  4'd0, 0,0,0,0, 4'd0, 32'h0,  32'h24};

      for (int i = 0; i < 8; i++) begin
         in_valid = vecs[i].valid; is_load_store = vecs[i].ls; is_store = vecs[i].st;
         rd_we = vecs[i].we; exe_out = vecs[i].exe; pc_in = vecs[i].pc; rd = vecs[i].rd;
         rs2_val = 32'h5555_aaaa;
         chk($sformatf("v%0d_in_ready", i), in_ready, 1);
         step();
         chk($sformatf("v%0d_wb_valid", i), wb_valid, vecs[i].e_valid);
         chk($sformatf("v%0d_wb_we", i), wb_we, vecs[i].e_we);
         chk($sformatf("v%0d_wb_rd", i), wb_rd, vecs[i].e_rd);
         chk($sformatf("v%0d_wb_pc", i), wb_pc, vecs[i].e_pc);
         chk($sformatf("v%0d_align_err", i), align_err, vecs[i].e_align);
         chk($sformatf("v%0d_dmem_req", i), dmem_req, 0);
         if (vecs[i].e_chk_data) chk($sformatf("v%0d_wb_data", i), wb_data, vecs[i].e_data);
      end
      idle_inputs();

      // Ack while idle is ignored
      dmem_ack = 1'b1; dmem_rdata = 32'hffff_ffff;
      step();
      dmem_ack = 1'b0;
      chk("idle_ack_wb_valid", wb_valid, 0);
      chk("idle_ack_req", dmem_req, 0);
      chk("idle_ack_in_ready", in_ready, 1);

      // Load, ack 3 cycles after req
      issue_mem(1'b0, 32'h100, 32'h0, 4'd5, 32'h40);
      step();
      idle_inputs();
      chk("ld_req", dmem_req, 1);
      chk("ld_we", dmem_we, 0);
      chk("ld_addr", dmem_addr, 32'h100);
      chk("ld_in_ready_c1", in_ready, 0);
      step();
      chk("ld_in_ready_c2", in_ready, 0);
      chk("ld_req_c2", dmem_req, 1);
      step();
      chk("ld_wb_valid_c3", wb_valid, 0);
      step();
      dmem_ack = 1'b1; dmem_rdata = 32'hdead_beef;
      chk("ld_in_ready_c4", in_ready, 0);
      step();
      dmem_ack = 1'b0; dmem_rdata = '0;
      chk("ld_wb_valid", wb_valid, 1);
      chk("ld_wb_we", wb_we, 1);
      chk("ld_wb_data", wb_data, 32'hdead_beef);
      chk("ld_wb_rd", wb_rd, 5);
      chk("ld_wb_pc", wb_pc, 32'h40);
      chk("ld_req_done", dmem_req, 0);
      chk("ld_in_ready_done", in_ready, 1);
      step();
      chk("ld_wb_pulse", wb_valid, 0);
      chk("ld_wb_data_hold", wb_data, 32'hdead_beef);

      // Store, ack in the same cycle as req
      issue_mem(1'b1, 32'h204, 32'hcafe_f00d, 4'd9, 32'h44);
      step();
      idle_inputs();
      dmem_ack = 1'b1;
      chk("st_req", dmem_req, 1);
      chk("st_we", dmem_we, 1);
      chk("st_addr", dmem_addr, 32'h204);
      chk("st_wdata", dmem_wdata, 32'hcafe_f00d);
      step();
      dmem_ack = 1'b0;
      chk("st_wb_valid", wb_valid, 1);
      chk("st_wb_we", wb_we, 0);
      chk("st_wb_data", wb_data, 0);
      chk("st_wb_pc", wb_pc, 32'h44);
      chk("st_bus_err", bus_err, 0);
      step();

      // Timeout with no ack
      issue_mem(1'b0, 32'h300, 32'h0, 4'd7, 32'h80);
      step();
      idle_inputs();
      req_cycles = 0;
      err_cycle = -1;
      for (int c = 1; c <= 8; c++) begin
         if (dmem_req) req_cycles++;
         if (bus_err) begin
            if (err_cycle < 0) err_cycle = c;
            chk("to_wb_valid", wb_valid, 1);
            chk("to_wb_we", wb_we, 0);
            chk("to_wb_pc", wb_pc, 32'h80);
            chk("to_in_ready", in_ready, 1);
         end
         step();
      end
      chk("to_req_cycles", req_cycles, TIMEOUT);
      chk("to_err_cycle", err_cycle, TIMEOUT + 1);

      // Ack on the last allowed cycle wins over the timeout
      issue_mem(1'b0, 32'h304, 32'h0, 4'd8, 32'h84);
      step();
      idle_inputs();
      for (int c = 1; c < TIMEOUT; c++) begin
         chk("late_req", dmem_req, 1);
         step();
      end
      dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
      step();
      dmem_ack = 1'b0;
      chk("late_wb_valid", wb_valid, 1);
      chk("late_bus_err", bus_err, 0);
      chk("late_wb_we", wb_we, 1);
      chk("late_wb_data", wb_data, 32'h1234_5678);
      chk("late_wb_rd", wb_rd, 8);
      step();
      chk("late_no_err_after", bus_err, 0);

      // Reset in the middle of a bus access
      issue_mem(1'b0, 32'h400, 32'h0, 4'd2, 32'h90);
      step();
      idle_inputs();
      step();
      chk("mid_req_before", dmem_req, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_req", dmem_req, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_wb_valid", wb_valid, 0);
      step();
      rst_n = 1'b1;
      step();
      dmem_ack = 1'b1; dmem_rdata = 32'hbad0_bad0;
      step();
      dmem_ack = 1'b0;
      chk("mid_late_ack_wb_valid", wb_valid, 0);
      chk("mid_late_ack_req", dmem_req, 0);
      chk("mid_late_ack_wb_data", wb_data, 0);
      step();
      chk("mid_late_ack_wb_valid2", wb_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
